// File: rtl/tt_sweep_checker_pkg.sv
// tt_sweep_pkg: shared types and helpers for the truth-table sweep checker.
//   state_e   - sweep FSM state encoding
//   clog2     - ceiling log2, used to size the settle counter
//   bin2gray  - binary to reflected Gray code (up to 8 bits)
package tt_sweep_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      SAMPLE = 2'd2,
      DONE   = 2'd3
   } state_e;

   function automatic int clog2(input int v);
      int r;
      for (r = 0; (1 << r) < v; r++) begin
      end
      return r;
   endfunction

   function automatic logic [7:0] bin2gray(input logic [7:0] b);
      return b ^ (b >> 1);
   endfunction

endpackage

// File: rtl/tt_sweep_checker_if.sv
// tt_sweep_checker_if: groups the sweep control, stimulus and result signals.
//   start, dut_f                       - driven by the master (bench / DUT side)
//   stim_out, busy, done, pass,
//   err_count, first_err_vec,
//   first_err_valid                    - driven by the checker (slave modport)
interface tt_sweep_checker_if #(
   parameter int N_IN = 4
);
   logic            start;
   logic            dut_f;
   logic [N_IN-1:0] stim_out;
   logic            busy;
   logic            done;
   logic            pass;
   logic [N_IN:0]   err_count;
   logic [N_IN-1:0] first_err_vec;
   logic            first_err_valid;

   modport master (
      output start, dut_f,
      input  stim_out, busy, done, pass, err_count, first_err_vec, first_err_valid
   );

   modport slave (
      input  start, dut_f,
      output stim_out, busy, done, pass, err_count, first_err_vec, first_err_valid
   );
endinterface

// File: rtl/tt_sweep_checker_settle_timer.sv
// tt_settle_timer: settle-time counter for the sweep checker.
//   clk, reset - clock, synchronous active-high reset
//   load_i     - restart the count at zero (takes priority over en_i)
//   en_i       - advance the count by one
//   expire_o   - count has reached CYCLES-1
module tt_settle_timer #(
   parameter int CYCLES = 2,
   parameter int W      = 1
) (
   input  logic clk,
   input  logic reset,
   input  logic load_i,
   input  logic en_i,
   output logic expire_o
);
   localparam logic [W-1:0] LAST = W'(CYCLES - 1);
   localparam logic [W-1:0] ONE  = W'(1);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i)    cnt_d = '0;
      else if (en_i) cnt_d = cnt_q + ONE;
   end

   always_ff @(posedge clk) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   assign expire_o = (cnt_q == LAST);
endmodule

// File: rtl/tt_sweep_checker.sv
// tt_sweep_checker: exhaustive truth-table sweep engine for an N_IN-input,
// single-output combinational DUT. On start it walks every input vector,
// holds each for SETTLE_CYC cycles, samples dut_f and compares it with EXP_TT.
//   clk, reset     - clock, synchronous active-high reset
//   bus (slave)    - start/dut_f in; stim_out, busy, done, pass, err_count,
//                    first_err_vec, first_err_valid out
// Build option: TT_SWEEP_GRAY_EN drives the vectors in Gray order; the
// compare index and first_err_vec then use the Gray value.
module tt_sweep_checker
   import tt_sweep_pkg::*;
#(
   parameter int                    N_IN       = 4,
   parameter int                    SETTLE_CYC = 2,
   parameter logic [(1<<N_IN)-1:0]  EXP_TT     = 16'hF888
) (
   input  logic clk,
   input  logic reset,
   tt_sweep_checker_if.slave bus
);
   // Counter needs at least one bit even when SETTLE_CYC==1.
   localparam int              CNT_W    = (clog2(SETTLE_CYC) < 1) ? 1 : clog2(SETTLE_CYC);
   localparam logic [N_IN-1:0] VEC_LAST = '1;
   localparam logic [N_IN-1:0] VEC_ONE  = N_IN'(1);
   localparam logic [N_IN:0]   ERR_ONE  = (N_IN+1)'(1);

   state_e          state_q, state_d;
   logic [N_IN-1:0] vec_q, vec_d;
   logic [N_IN:0]   err_q, err_d;
   logic [N_IN-1:0] fvec_q, fvec_d;
   logic            fvalid_q, fvalid_d;
   logic            pass_q, pass_d;

   logic            tmr_load, tmr_en, tmr_expire;
   logic [N_IN-1:0] cur_vec;
   logic            mismatch;

`ifdef TT_SWEEP_GRAY_EN
   assign cur_vec = N_IN'(bin2gray(8'(vec_q)));
`else
   assign cur_vec = vec_q;
`endif

   assign mismatch = (bus.dut_f != EXP_TT[cur_vec]);

   tt_settle_timer #(
      .CYCLES (SETTLE_CYC),
      .W      (CNT_W)
   ) u_timer (
      .clk      (clk),
      .reset    (reset),
      .load_i   (tmr_load),
      .en_i     (tmr_en),
      .expire_o (tmr_expire)
   );

   always_comb begin
      state_d  = state_q;
      vec_d    = vec_q;
      err_d    = err_q;
      fvec_d   = fvec_q;
      fvalid_d = fvalid_q;
      pass_d   = pass_q;
      tmr_load = 1'b0;
      tmr_en   = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               state_d  = SETTLE;
               vec_d    = '0;
               tmr_load = 1'b1;
               err_d    = '0;
               fvec_d   = '0;
               fvalid_d = 1'b0;
               pass_d   = 1'b0;
            end
         end
         SETTLE: begin
            if (tmr_expire) state_d = SAMPLE;
            else            tmr_en  = 1'b1;
         end
         SAMPLE: begin
            if (mismatch) begin
               err_d = err_q + ERR_ONE;
               if (!fvalid_q) begin
                  fvec_d   = cur_vec;
                  fvalid_d = 1'b1;
               end
            end
            // Terminate on all-ones rather than wrap so N_IN=8 stops at 255.
            if (vec_q == VEC_LAST) begin
               state_d = DONE;
               // Uses err_d so the final sample is counted and pass is
               // already valid alongside the done pulse.
               pass_d  = (err_d == '0);
            end else begin
               vec_d    = vec_q + VEC_ONE;
               tmr_load = 1'b1;
               state_d  = SETTLE;
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         vec_q    <= '0;
         err_q    <= '0;
         fvec_q   <= '0;
         fvalid_q <= 1'b0;
         pass_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         vec_q    <= vec_d;
         err_q    <= err_d;
         fvec_q   <= fvec_d;
         fvalid_q <= fvalid_d;
         pass_q   <= pass_d;
      end
   end

   assign bus.stim_out        = (state_q == SETTLE || state_q == SAMPLE) ? cur_vec : '0;
   assign bus.busy            = (state_q != IDLE);
   assign bus.done            = (state_q == DONE);
   assign bus.pass            = pass_q;
   assign bus.err_count       = err_q;
   assign bus.first_err_vec   = fvec_q;
   assign bus.first_err_valid = fvalid_q;
endmodule

// File: tb/tb_tt_sweep_checker.sv
module tb_tt_sweep_checker;
   localparam int N_IN   = 4;
   localparam int SETTLE = 2;
   localparam int LAT    = (1 << N_IN) * (SETTLE + 1);

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   tt_sweep_checker_if #(.N_IN(N_IN)) bus ();

   tt_sweep_checker #(
      .N_IN       (N_IN),
      .SETTLE_CYC (SETTLE),
      .EXP_TT     (16'hF888)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // Behavioural DUT: a table lookup on the stimulus vector.
   logic [15:0] dut_tt;
   assign bus.dut_f = dut_tt[bus.stim_out];

   typedef struct {
      logic [4:0] err;
      logic [3:0] fvec;
      logic       fvalid;
      logic       pass;
      int         done_cyc;
   } exp_t;

   exp_t sb[$];
   int   n_chk    = 0;
   int   n_fail   = 0;
   int   cyc      = 0;
   int   done_cnt = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic logic [3:0] exp_stim(input int k);
      logic [3:0] b;
      b = 4'(k);
`ifdef TT_SWEEP_GRAY_EN
      return b ^ {1'b0, b[3:1]};
`else
      return b;
`endif
   endfunction

   // Monitor: every done pulse consumes one scoreboard entry.
   always @(negedge clk) begin : mon
      exp_t e;
      if (reset === 1'b0 && bus.done === 1'b1) begin
         done_cnt++;
         if (sb.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
         else begin
            e = sb.pop_front();
            chk("done_cycle",      cyc,                 e.done_cyc);
            chk("err_count",       bus.err_count,       e.err);
            chk("first_err_vec",   bus.first_err_vec,   e.fvec);
            chk("first_err_valid", bus.first_err_valid, e.fvalid);
            chk("pass",            bus.pass,            e.pass);
         end
      end
   end

   task automatic wait_empty();
      int t = 0;
      while (sb.size() != 0 && t < 300) begin
         @(negedge clk);
         t++;
      end
      if (sb.size() != 0) begin
         chk("done_timeout", 32'd0, 32'd1);
         sb.delete();
      end
   endtask

   task automatic sweep(input logic [15:0] tt, input logic [4:0] e_err, input logic [3:0] e_fvec,
                        input logic e_fv, input logic e_pass, input bit chk_stim);
      int acc;
      logic [3:0] prev;
      @(negedge clk);
      dut_tt    = tt;
      bus.start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      acc = cyc;
      sb.push_back('{e_err, e_fvec, e_fv, e_pass, acc + LAT});
      chk("busy_after_start",   bus.busy,            32'd1);
      chk("err_cleared",        bus.err_count,       32'd0);
      chk("fvalid_cleared",     bus.first_err_valid, 32'd0);
      if (chk_stim) begin
         prev = '0;
         for (int k = 0; k < 16; k++) begin
            repeat ((k == 0) ? 1 : 3) @(negedge clk);
            chk($sformatf("stim_%0d", k), bus.stim_out, exp_stim(k));
`ifdef TT_SWEEP_GRAY_EN
            if (k > 0) chk($sformatf("hamming_%0d", k), $countones(bus.stim_out ^ prev), 32'd1);
`endif
            prev = bus.stim_out;
         end
      end
      wait_empty();
      @(negedge clk);
      chk("busy_idle",   bus.busy,     32'd0);
      chk("stim_idle",   bus.stim_out, 32'd0);
      chk("pass_stable", bus.pass,     e_pass);
   endtask

   initial begin
      int acc, d0;
      reset     = 1'b1;
      bus.start = 1'b0;
      dut_tt    = 16'hF888;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_stim",   bus.stim_out,        32'd0);
      chk("rst_busy",   bus.busy,            32'd0);
      chk("rst_done",   bus.done,            32'd0);
      chk("rst_pass",   bus.pass,            32'd0);
      chk("rst_err",    bus.err_count,       32'd0);
      chk("rst_fvec",   bus.first_err_vec,   32'd0);
      chk("rst_fvalid", bus.first_err_valid, 32'd0);
      reset = 1'b0;

      // Correct DUT, wrong vector 5, constant 0, then correct again.
      sweep(16'hF888, 5'd0, 4'h0, 1'b0, 1'b1, 1'b1);
      sweep(16'hF8A8, 5'd1, 4'h5, 1'b1, 1'b0, 1'b0);
      sweep(16'h0000, 5'd7, 4'h3, 1'b1, 1'b0, 1'b0);
      sweep(16'hF888, 5'd0, 4'h0, 1'b0, 1'b1, 1'b0);

      // Start held high: one done at +48, re-accepted on the first IDLE cycle.
      @(negedge clk);
      dut_tt    = 16'hF888;
      bus.start = 1'b1;
      d0        = done_cnt;
      @(posedge clk);
      @(negedge clk);
      acc = cyc;
      sb.push_back('{5'd0, 4'h0, 1'b0, 1'b1, acc + LAT});
      sb.push_back('{5'd0, 4'h0, 1'b0, 1'b1, acc + 2 + 2 * LAT});
      while (cyc < acc + 60) begin
         @(negedge clk);
         if (cyc == acc + LAT + 1) chk("hold_busy_low",  bus.busy, 32'd0);
         if (cyc == acc + LAT + 2) chk("hold_reaccept",  bus.busy, 32'd1);
      end
      chk("hold_one_done", done_cnt - d0, 32'd1);
      bus.start = 1'b0;
      wait_empty();
      chk("hold_two_done", done_cnt - d0, 32'd2);

      // Reset mid-sweep aborts with no done pulse.
      repeat (2) @(negedge clk);
      dut_tt    = 16'h0000;
      bus.start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      acc = cyc;
      repeat (19) @(negedge clk);
      chk("pre_rst_busy", bus.busy, 32'd1);
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      chk("abort_stim",   bus.stim_out,        32'd0);
      chk("abort_busy",   bus.busy,            32'd0);
      chk("abort_err",    bus.err_count,       32'd0);
      chk("abort_fvalid", bus.first_err_valid, 32'd0);
      chk("abort_pass",   bus.pass,            32'd0);
      d0 = done_cnt;
      repeat (100) @(negedge clk);
      chk("abort_no_done", done_cnt - d0, 32'd0);
      chk("sb_drained", sb.size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
